// File: rtl/acm_pkg.sv
// Constants and FSM encoding shared by the ACM IN packetizer and its bench.
package acm_pkg;

  localparam int ACM_DEPTH        = 128;
  localparam int ACM_MAX_PKT      = 64;
  localparam int ACM_IDLE_TIMEOUT = 4800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } acm_state_t;

endpackage

// File: rtl/acm_fifo_sync.sv
// Single-clock FIFO, RAM storage plus a registered head word (head valid 2 cycles after a write into empty).
// not_full is registered and drops as soon as DEPTH entries are held; writes are ignored when full.
module acm_fifo_sync #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                   clk_usb,
  input  logic                   rst_usb,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   not_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             head_valid;
  logic             wr_fire;
  logic             rd_fire;
  logic             load;
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    count_nxt;

  assign wr_fire   = wr_en & not_full;
  assign rd_fire   = rd_en & head_valid;
  // count includes the head register, so the RAM alone holds count - head_valid
  assign ram_cnt   = count - {{AW{1'b0}}, head_valid};
  assign load      = (ram_cnt != '0) && (!head_valid || rd_fire);
  assign count_nxt = count + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};

  always_ff @(posedge clk_usb) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
      not_full   <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        head       <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
        head_valid <= 1'b1;
      end else if (rd_fire) begin
        head_valid <= 1'b0;
      end
      count    <= count_nxt;
      not_full <= (count_nxt != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/acm_in_packetizer.sv
// Store-and-forward packetizer: emits MAX_PKT packets, or a short packet after IDLE_TIMEOUT idle cycles.
// Output held while m_ready is low; input accepted whenever the FIFO is not full, including during DRAIN.
module acm_in_packetizer
  import acm_pkg::*;
#(
  parameter int DEPTH        = ACM_DEPTH,
  parameter int MAX_PKT      = ACM_MAX_PKT,
  parameter int IDLE_TIMEOUT = ACM_IDLE_TIMEOUT
) (
  input  logic                   clk_usb,
  input  logic                   rst_usb,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [7:0]             m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   flush_now,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  acm_state_t    state;
  logic [TW-1:0] idle_cnt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] fill_after;
  logic          short_pkt;
  logic          accept;
  logic          pop;

  assign accept     = s_valid & s_ready;
  assign pop        = m_valid & m_ready;
  assign fill_after = fill_level + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};

  acm_fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_usb  (clk_usb),
    .rst_usb  (rst_usb),
    .wr_en    (accept),
    .wr_data  (s_data),
    .rd_en    (pop),
    .head     (m_data),
    .count    (fill_level),
    .not_full (s_ready)
  );

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      state     <= ST_IDLE;
      idle_cnt  <= '0;
      remaining <= '0;
      short_pkt <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      flush_now <= 1'b0;
    end else begin
      flush_now <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (accept) state <= ST_FILL;
        end
        ST_FILL: begin
          idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
          if (fill_level >= CW'(MAX_PKT)) begin
            state     <= ST_DRAIN;
            remaining <= CW'(MAX_PKT);
            short_pkt <= 1'b0;
            m_valid   <= 1'b1;
            m_last    <= (MAX_PKT == 1);
            idle_cnt  <= '0;
          // a byte arriving on the timeout cycle restarts the idle window instead
          end else if (!accept && idle_cnt == TW'(IDLE_TIMEOUT - 1) && fill_level != '0) begin
            state     <= ST_DRAIN;
            remaining <= fill_level;
            short_pkt <= 1'b1;
            m_valid   <= 1'b1;
            m_last    <= (fill_level == CW'(1));
            idle_cnt  <= '0;
          end
        end
        ST_DRAIN: begin
          idle_cnt <= '0;
          if (pop) begin
            remaining <= remaining - 1'b1;
            m_last    <= (remaining == CW'(2));
            if (m_last) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              flush_now <= short_pkt;
              state     <= (fill_after != '0) ? ST_FILL : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acm_in_packetizer.sv
// Randomized scoreboard bench: accepted bytes and expected packet lengths are queued, a monitor checks the output stream.
module tb_acm_in_packetizer;

  localparam int DEPTH        = 128;
  localparam int MAX_PKT      = 64;
  localparam int IDLE_TIMEOUT = 4800;
  localparam int BOUND        = 20000;

  logic       clk_usb = 1'b0;
  logic       rst_usb = 1'b1;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       flush_now;
  logic [7:0] fill_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  byte unsigned data_q[$];
  int           len_q[$];
  int           pos          = 0;
  int           model_cnt    = 0;
  int           popped       = 0;
  int           rdy_mode     = 0;
  int           last_acc_cyc = 0;
  bit           flush_exp    = 1'b0;
  bit           skip_rdy     = 1'b0;
  bit           time_chk     = 1'b0;
  bit           prev_stall   = 1'b0;
  bit           prev_vld     = 1'b0;
  logic [7:0]   prev_data    = 8'h00;
  logic         prev_last    = 1'b0;

  acm_in_packetizer #(
    .DEPTH        (DEPTH),
    .MAX_PKT      (MAX_PKT),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk_usb    (clk_usb),
    .rst_usb    (rst_usb),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush_now  (flush_now),
    .fill_level (fill_level)
  );

  always #10 clk_usb = ~clk_usb;
  always @(posedge clk_usb) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    checks++;
    failures++;
    $display("FAIL %s: got %s required %s at cycle %0d", name, got, want, cyc);
  endtask

  initial begin
    forever begin
      @(posedge clk_usb);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  always @(negedge clk_usb) begin
    bit el;
    bit acc;
    bit pp;
    if (rst_usb) begin
      data_q.delete();
      len_q.delete();
      pos        = 0;
      model_cnt  = 0;
      flush_exp  = 1'b0;
      skip_rdy   = 1'b1;
      prev_stall = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      acc = s_valid && s_ready;
      pp  = m_valid && m_ready;
      chk("fill_level", fill_level, model_cnt);
      if (!skip_rdy) chk("s_ready_vs_level", s_ready, model_cnt != DEPTH);
      skip_rdy = 1'b0;
      chk("flush_now", flush_now, flush_exp);
      flush_exp = 1'b0;
      if (prev_stall && m_valid) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (time_chk && m_valid && !prev_vld) begin
        chk("timeout_latency", cyc - last_acc_cyc, IDLE_TIMEOUT);
        time_chk = 1'b0;
      end
      if (acc) begin
        data_q.push_back(s_data);
        last_acc_cyc = cyc + 1;
      end
      if (pp) begin
        popped++;
        if (data_q.size() == 0) fail("unexpected_output", $sformatf("byte 0x%0h", m_data), "no output");
        else chk("m_data", m_data, data_q.pop_front());
        if (len_q.size() == 0) fail("unexpected_packet", "output byte", "no packet pending");
        else begin
          el = (pos == len_q[0] - 1);
          chk("m_last", m_last, el);
          if (el) begin
            flush_exp = (len_q[0] < MAX_PKT);
            void'(len_q.pop_front());
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      model_cnt  = model_cnt + int'(acc) - int'(pp);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_vld   = m_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    while (!ok) begin
      @(negedge clk_usb);
      ok = s_ready;
      @(posedge clk_usb);
      #1;
      n++;
      if (!ok && n > BOUND) begin
        fail("send_timeout", "s_ready low", "byte accepted");
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    do begin
      @(negedge clk_usb);
      n++;
    end while ((data_q.size() != 0 || len_q.size() != 0 || m_valid) && n < BOUND);
    if (n >= BOUND) fail("drain_timeout", $sformatf("%0d bytes pending", data_q.size()), "all drained");
    repeat (3) @(posedge clk_usb);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk_usb);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_flush_now", flush_now, 0);
    chk("rst_fill_level", fill_level, 0);
    chk("rst_s_ready", s_ready, 0);
    @(posedge clk_usb);
    #1;
    rst_usb = 1'b0;
    @(negedge clk_usb);
    chk("s_ready_before_edge", s_ready, 0);
    @(posedge clk_usb);
    #1;
    chk("s_ready_after_edge", s_ready, 1);

    // one full packet, back to back
    rdy_mode = 1;
    len_q.push_back(64);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    wait_drained();

    // short packet closed by the idle timeout
    time_chk = 1'b1;
    len_q.push_back(5);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    wait_drained();
    if (time_chk) fail("timeout_seen", "no drain start", "drain start");
    time_chk = 1'b0;

    // fill to capacity with the sink stalled
    rdy_mode = 0;
    len_q.push_back(64);
    len_q.push_back(64);
    len_q.push_back(2);
    fork
      begin
        for (int i = 0; i < 130; i++) send_byte(8'(i + 16));
      end
      begin
        int n;
        n = 0;
        while (fill_level != 8'd128 && n < 1000) begin
          @(negedge clk_usb);
          n++;
        end
        if (n >= 1000) fail("full_wait", $sformatf("fill %0d", fill_level), "fill 128");
        repeat (5) @(negedge clk_usb);
        chk("full_level_held", fill_level, 128);
        chk("full_s_ready", s_ready, 0);
        chk("full_m_valid", m_valid, 1);
        chk("full_head", m_data, 16);
        chk("full_m_last", m_last, 0);
        @(posedge clk_usb);
        #1;
        rdy_mode = 1;
      end
    join
    wait_drained();

    // random bytes, random gaps, random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 15; i++) len_q.push_back(64);
    len_q.push_back(40);
    for (int i = 0; i < 1000; i++) begin
      int g;
      send_byte(8'($urandom));
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(posedge clk_usb);
        #1;
      end
    end
    wait_drained();

    // 64th byte lands on the cycle the timeout would fire
    rdy_mode = 1;
    len_q.push_back(64);
    for (int i = 0; i < 63; i++) send_byte(8'(8'hC0 + i));
    repeat (IDLE_TIMEOUT - 1) @(posedge clk_usb);
    #1;
    send_byte(8'h5A);
    wait_drained();

    // reset in the middle of a drain, then a fresh short packet
    len_q.push_back(64);
    begin
      int base;
      int n;
      base = popped;
      for (int i = 0; i < 64; i++) send_byte(8'(i + 64));
      n = 0;
      while (popped - base < 10 && n < 1000) begin
        @(negedge clk_usb);
        n++;
      end
      if (n >= 1000) fail("drain_start_wait", $sformatf("%0d popped", popped - base), "10 popped");
    end
    @(posedge clk_usb);
    #1;
    rst_usb = 1'b1;
    repeat (2) @(negedge clk_usb);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_last", m_last, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_flush_now", flush_now, 0);
    chk("midrst_fill_level", fill_level, 0);
    chk("midrst_s_ready", s_ready, 0);
    @(posedge clk_usb);
    #1;
    rst_usb = 1'b0;
    len_q.push_back(3);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i));
    wait_drained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: got cycle %0d required completion earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
